// File: rtl/acc4_seq_pkg.sv
// Shared definitions for the acc4_seq sequencing accumulator and its adder.
package acc4_seq_pkg;

    // Operation codes presented on OP
    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_CLR  = 2'b11
    } op_t;

    // Sequencer states: IDLE accepts requests, WAIT lets the ripple chain settle
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Cycles between driving adder inputs and capturing its outputs
    localparam int DEFAULT_SETTLE = 2;

    // Two's-complement overflow: operands agree in sign, result disagrees
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/acc4_seq_cpa.sv
// 4-bit ripple-carry adder sitting beside acc4_seq at the parent level.
module acc4_seq_cpa (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Ci,
    output logic [3:0] S,
    output logic       Co
);

    logic [4:0] carry;

    assign carry[0] = Ci;

    // One full adder per bit, carry rippling from bit 0 upward
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            logic p;
            assign p            = A[gi] ^ B[gi];
            assign S[gi]        = p ^ carry[gi];
            assign carry[gi+1]  = (A[gi] & B[gi]) | (p & carry[gi]);
        end
    endgenerate

    assign Co = carry[4];

endmodule

// File: rtl/acc4_seq.sv
// Sequencing accumulator: drives an external combinational CPA, waits SETTLE
// cycles for the ripple chain, then captures the sum and status flags.
module acc4_seq
    import acc4_seq_pkg::*;
#(
    parameter int SETTLE = DEFAULT_SETTLE
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [1:0] OP,
    input  logic [3:0] D,
    output logic [3:0] AA,
    output logic [3:0] AB,
    output logic       ACi,
    input  logic [3:0] AS,
    input  logic       ACo,
    output logic [3:0] ACC,
    output logic       C,
    output logic       V,
    output logic       Z,
    output logic       BUSY,
    output logic       DONE
);

    // Counter reload so that capture lands exactly SETTLE edges after the start edge
    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] cnt_reg;
    logic [3:0] acc_reg;
    logic [3:0] aa_reg;
    logic [3:0] ab_reg;
    logic       aci_reg;
    logic       c_reg;
    logic       v_reg;
    logic       z_reg;
    logic       done_reg;
    logic       accept_arith;
    logic       capture;

    // Decode the two events that move the sequencer between states
    always_comb begin
        accept_arith = (state_reg == IDLE) && START && ((OP == OP_ADD) || (OP == OP_SUB));
        capture      = (state_reg == WAIT) && (cnt_reg == 4'd0);
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: only ADD/SUB need the adder, so only they enter WAIT
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept_arith) state_next = WAIT;
            WAIT:    if (capture)      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: BUSY follows the state, everything else is registered
    always_comb begin
        BUSY = (state_reg == WAIT);
        AA   = aa_reg;
        AB   = ab_reg;
        ACi  = aci_reg;
        ACC  = acc_reg;
        C    = c_reg;
        V    = v_reg;
        Z    = z_reg;
        DONE = done_reg;
    end

    // Datapath: operand launch, settle countdown, result capture and flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_reg  <= 4'd0;
            acc_reg  <= 4'd0;
            aa_reg   <= 4'd0;
            ab_reg   <= 4'd0;
            aci_reg  <= 1'b0;
            c_reg    <= 1'b0;
            v_reg    <= 1'b0;
            z_reg    <= 1'b1;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (START) begin
                        case (OP)
                            OP_ADD: begin
                                aa_reg  <= acc_reg;
                                ab_reg  <= D;
                                aci_reg <= 1'b0;
                                cnt_reg <= CNT_INIT;
                            end
                            OP_SUB: begin
                                // Subtract as ACC + ~D + 1
                                aa_reg  <= acc_reg;
                                ab_reg  <= ~D;
                                aci_reg <= 1'b1;
                                cnt_reg <= CNT_INIT;
                            end
                            OP_LOAD: begin
                                acc_reg  <= D;
                                c_reg    <= 1'b0;
                                v_reg    <= 1'b0;
                                z_reg    <= (D == 4'd0);
                                done_reg <= 1'b1;
                            end
                            default: begin
                                acc_reg  <= 4'd0;
                                c_reg    <= 1'b0;
                                v_reg    <= 1'b0;
                                z_reg    <= 1'b1;
                                done_reg <= 1'b1;
                            end
                        endcase
                    end
                end
                WAIT: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        // Adder inputs have been stable for SETTLE cycles
                        acc_reg  <= AS;
                        c_reg    <= ACo;
                        v_reg    <= signed_ovf(aa_reg[3], ab_reg[3], AS[3]);
                        z_reg    <= (AS == 4'd0);
                        done_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acc4_seq.sv
// Self-checking bench: three acc4_seq instances (SETTLE = 1, 2, 3), each wired
// to its own ripple-carry adder, compared against an arithmetic reference model.
module tb_acc4_seq;
    import acc4_seq_pkg::*;

    localparam int NU = 3;

    logic       CLK;
    logic       rst_s   [NU];
    logic       start_s [NU];
    logic [1:0] op_s    [NU];
    logic [3:0] d_s     [NU];
    logic [3:0] aa_s    [NU];
    logic [3:0] ab_s    [NU];
    logic       aci_s   [NU];
    logic [3:0] as_s    [NU];
    logic       aco_s   [NU];
    logic [3:0] acc_s   [NU];
    logic       c_s     [NU];
    logic       v_s     [NU];
    logic       z_s     [NU];
    logic       busy_s  [NU];
    logic       done_s  [NU];

    // Reference model state per unit
    logic [3:0] m_acc [NU];
    logic       m_c   [NU];
    logic       m_v   [NU];
    logic       m_z   [NU];
    logic [3:0] m_aa  [NU];
    logic [3:0] m_ab  [NU];
    logic       m_aci [NU];

    int checks;
    int failures;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Unit gi has SETTLE = gi + 1
    generate
        for (genvar gi = 0; gi < NU; gi++) begin : g_unit
            acc4_seq #(.SETTLE(gi + 1)) u_dut (
                .CLK   (CLK),
                .RST   (rst_s[gi]),
                .START (start_s[gi]),
                .OP    (op_s[gi]),
                .D     (d_s[gi]),
                .AA    (aa_s[gi]),
                .AB    (ab_s[gi]),
                .ACi   (aci_s[gi]),
                .AS    (as_s[gi]),
                .ACo   (aco_s[gi]),
                .ACC   (acc_s[gi]),
                .C     (c_s[gi]),
                .V     (v_s[gi]),
                .Z     (z_s[gi]),
                .BUSY  (busy_s[gi]),
                .DONE  (done_s[gi])
            );
            acc4_seq_cpa u_cpa (
                .A  (aa_s[gi]),
                .B  (ab_s[gi]),
                .Ci (aci_s[gi]),
                .S  (as_s[gi]),
                .Co (aco_s[gi])
            );
        end
    endgenerate

    task automatic model_reset(input int u);
        m_acc[u] = 4'd0; m_c[u] = 1'b0; m_v[u] = 1'b0; m_z[u] = 1'b1;
        m_aa[u]  = 4'd0; m_ab[u] = 4'd0; m_aci[u] = 1'b0;
    endtask

    // Plain integer arithmetic on unsigned and signed interpretations
    task automatic model_op(input int u, input logic [1:0] op, input logic [3:0] d);
        int a, b, sa, sb, r, sr;
        a  = int'(m_acc[u]);
        b  = int'(d);
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        case (op)
            OP_LOAD: begin m_acc[u] = d; m_c[u] = 1'b0; m_v[u] = 1'b0; end
            OP_CLR:  begin m_acc[u] = 4'd0; m_c[u] = 1'b0; m_v[u] = 1'b0; end
            OP_ADD: begin
                r  = a + b;
                sr = sa + sb;
                m_acc[u] = 4'(r % 16);
                m_c[u]   = (r > 15);
                m_v[u]   = (sr > 7) || (sr < -8);
                m_aa[u]  = 4'(a); m_ab[u] = d; m_aci[u] = 1'b0;
            end
            default: begin
                r  = a - b;
                sr = sa - sb;
                m_acc[u] = 4'((r + 16) % 16);
                m_c[u]   = (a >= b);
                m_v[u]   = (sr > 7) || (sr < -8);
                m_aa[u]  = 4'(a); m_ab[u] = ~d; m_aci[u] = 1'b1;
            end
        endcase
        m_z[u] = (m_acc[u] == 4'd0);
    endtask

    task automatic test_reset();
        for (int u = 0; u < NU; u++) begin
            rst_s[u] = 1'b1; start_s[u] = 1'b0; op_s[u] = 2'b00; d_s[u] = 4'd0;
        end
        repeat (2) @(posedge CLK);
        #1;
        for (int u = 0; u < NU; u++) begin
            model_reset(u);
            checks++;
            if (acc_s[u] !== 4'd0 || c_s[u] !== 1'b0 || v_s[u] !== 1'b0 || z_s[u] !== 1'b1 ||
                busy_s[u] !== 1'b0 || done_s[u] !== 1'b0 || aa_s[u] !== 4'd0 ||
                ab_s[u] !== 4'd0 || aci_s[u] !== 1'b0) begin
                failures++;
                $display("FAIL reset u%0d: acc=%0h c=%b v=%b z=%b busy=%b done=%b aa=%0h ab=%0h aci=%b, want 0 0 0 1 0 0 0 0 0",
                         u, acc_s[u], c_s[u], v_s[u], z_s[u], busy_s[u], done_s[u], aa_s[u], ab_s[u], aci_s[u]);
            end
            rst_s[u] = 1'b0;
        end
    endtask

    // Issue one operation, optionally pulse START (ADD, D=1) during BUSY, check result and timing
    task automatic do_op(input int u, input logic [1:0] op, input logic [3:0] d, input bit glitch);
        int  n;
        int  want_lat;
        bit  arith;
        arith    = (op == OP_ADD) || (op == OP_SUB);
        want_lat = arith ? u + 1 : 0;
        @(negedge CLK);
        op_s[u] = op; d_s[u] = d; start_s[u] = 1'b1;
        @(posedge CLK);
        #1;
        start_s[u] = 1'b0;
        if (glitch && arith) begin
            start_s[u] = 1'b1; op_s[u] = OP_ADD; d_s[u] = 4'd1;
        end else begin
            op_s[u] = ~op; d_s[u] = ~d;
        end
        n = 0;
        while (done_s[u] !== 1'b1 && n < 40) begin
            checks++;
            if (busy_s[u] !== 1'b1) begin
                failures++;
                $display("FAIL busy_wait u%0d cyc%0d: got %b want 1", u, n, busy_s[u]);
            end
            @(posedge CLK);
            #1;
            n++;
        end
        start_s[u] = 1'b0;
        model_op(u, op, d);
        checks++;
        if (n !== want_lat) begin
            failures++;
            $display("FAIL latency u%0d op%0d: got %0d edges want %0d", u, op, n, want_lat);
        end
        checks++;
        if (acc_s[u] !== m_acc[u] || c_s[u] !== m_c[u] || v_s[u] !== m_v[u] || z_s[u] !== m_z[u]) begin
            failures++;
            $display("FAIL result u%0d op%0d d=%0h: acc=%0h c=%b v=%b z=%b want acc=%0h c=%b v=%b z=%b",
                     u, op, d, acc_s[u], c_s[u], v_s[u], z_s[u], m_acc[u], m_c[u], m_v[u], m_z[u]);
        end
        checks++;
        if (aa_s[u] !== m_aa[u] || ab_s[u] !== m_ab[u] || aci_s[u] !== m_aci[u] || busy_s[u] !== 1'b0) begin
            failures++;
            $display("FAIL adder_io u%0d: aa=%0h ab=%0h aci=%b busy=%b want aa=%0h ab=%0h aci=%b busy=0",
                     u, aa_s[u], ab_s[u], aci_s[u], busy_s[u], m_aa[u], m_ab[u], m_aci[u]);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (done_s[u] !== 1'b0 || busy_s[u] !== 1'b0 || acc_s[u] !== m_acc[u]) begin
            failures++;
            $display("FAIL done_pulse u%0d: done=%b busy=%b acc=%0h want done=0 busy=0 acc=%0h",
                     u, done_s[u], busy_s[u], acc_s[u], m_acc[u]);
        end
        $display("op u%0d op=%0d d=%0h -> acc=%0h c=%b v=%b z=%b lat=%0d", u, op, d, acc_s[u], c_s[u], v_s[u], z_s[u], n);
    endtask

    task automatic test_directed(input int u);
        do_op(u, OP_LOAD, 4'd5, 0);
        do_op(u, OP_ADD,  4'd7, 0);
        checks++;
        if (acc_s[u] !== 4'b1100 || c_s[u] !== 1'b0 || v_s[u] !== 1'b1 || z_s[u] !== 1'b0) begin
            failures++;
            $display("FAIL add_5_7 u%0d: acc=%b c=%b v=%b z=%b want 1100 0 1 0", u, acc_s[u], c_s[u], v_s[u], z_s[u]);
        end
        do_op(u, OP_LOAD, 4'd12, 0);
        do_op(u, OP_ADD,  4'd9,  0);
        do_op(u, OP_LOAD, 4'd5,  0);
        do_op(u, OP_SUB,  4'd5,  0);
        do_op(u, OP_LOAD, 4'd3,  0);
        do_op(u, OP_SUB,  4'd5,  0);
        checks++;
        if (acc_s[u] !== 4'b1110 || c_s[u] !== 1'b0 || v_s[u] !== 1'b0) begin
            failures++;
            $display("FAIL sub_3_5 u%0d: acc=%b c=%b v=%b want 1110 0 0", u, acc_s[u], c_s[u], v_s[u]);
        end
        do_op(u, OP_LOAD, 4'd15, 0);
        do_op(u, OP_CLR,  4'd6,  0);
    endtask

    task automatic test_ignore_busy(input int u);
        do_op(u, OP_LOAD, 4'd2, 0);
        do_op(u, OP_ADD,  4'd4, 1);
        do_op(u, OP_SUB,  4'd9, 1);
    endtask

    // START held through the DONE cycle launches the next operation on that edge
    task automatic test_back_to_back(input int u, input logic [3:0] d1, input logic [3:0] d2);
        int n;
        @(negedge CLK);
        op_s[u] = OP_ADD; d_s[u] = d1; start_s[u] = 1'b1;
        @(posedge CLK);
        #1;
        op_s[u] = OP_SUB; d_s[u] = d2;
        n = 0;
        while (done_s[u] !== 1'b1 && n < 40) begin
            @(posedge CLK);
            #1;
            n++;
        end
        model_op(u, OP_ADD, d1);
        checks++;
        if (n !== u + 1 || acc_s[u] !== m_acc[u]) begin
            failures++;
            $display("FAIL b2b_first u%0d: lat=%0d acc=%0h want lat=%0d acc=%0h", u, n, acc_s[u], u + 1, m_acc[u]);
        end
        @(posedge CLK);
        #1;
        start_s[u] = 1'b0;
        checks++;
        if (busy_s[u] !== 1'b1 || done_s[u] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept u%0d: busy=%b done=%b want busy=1 done=0", u, busy_s[u], done_s[u]);
        end
        n = 0;
        while (done_s[u] !== 1'b1 && n < 40) begin
            @(posedge CLK);
            #1;
            n++;
        end
        model_op(u, OP_SUB, d2);
        checks++;
        if (n !== u + 1 || acc_s[u] !== m_acc[u] || c_s[u] !== m_c[u] || v_s[u] !== m_v[u]) begin
            failures++;
            $display("FAIL b2b_second u%0d: lat=%0d acc=%0h c=%b v=%b want lat=%0d acc=%0h c=%b v=%b",
                     u, n, acc_s[u], c_s[u], v_s[u], u + 1, m_acc[u], m_c[u], m_v[u]);
        end
        @(posedge CLK);
        #1;
        $display("b2b u%0d add %0h then sub %0h -> acc=%0h", u, d1, d2, acc_s[u]);
    endtask

    // Reset one cycle into WAIT must abort with no capture and no DONE
    task automatic test_abort(input int u);
        int seen_done;
        do_op(u, OP_LOAD, 4'd9, 0);
        @(negedge CLK);
        op_s[u] = OP_ADD; d_s[u] = 4'd6; start_s[u] = 1'b1;
        @(posedge CLK);
        #1;
        start_s[u] = 1'b0;
        @(posedge CLK);
        #1;
        rst_s[u] = 1'b1;
        @(posedge CLK);
        #1;
        rst_s[u] = 1'b0;
        model_reset(u);
        checks++;
        if (done_s[u] !== 1'b0 || acc_s[u] !== 4'd0 || z_s[u] !== 1'b1 || c_s[u] !== 1'b0 ||
            v_s[u] !== 1'b0 || busy_s[u] !== 1'b0 || aa_s[u] !== 4'd0 || ab_s[u] !== 4'd0 || aci_s[u] !== 1'b0) begin
            failures++;
            $display("FAIL abort u%0d: done=%b acc=%0h z=%b c=%b v=%b busy=%b aa=%0h ab=%0h aci=%b want all reset",
                     u, done_s[u], acc_s[u], z_s[u], c_s[u], v_s[u], busy_s[u], aa_s[u], ab_s[u], aci_s[u]);
        end
        seen_done = 0;
        repeat (4) begin
            @(posedge CLK);
            #1;
            if (done_s[u] !== 1'b0) seen_done++;
        end
        checks++;
        if (seen_done != 0 || acc_s[u] !== 4'd0) begin
            failures++;
            $display("FAIL abort_quiet u%0d: done pulses=%0d acc=%0h want 0 and 0", u, seen_done, acc_s[u]);
        end
        $display("abort u%0d -> acc=%0h z=%b", u, acc_s[u], z_s[u]);
    endtask

    task automatic test_random(input int count);
        int u;
        logic [1:0] op;
        logic [3:0] d;
        bit g;
        for (int i = 0; i < count; i++) begin
            u  = int'($urandom_range(0, NU - 1));
            op = 2'($urandom_range(0, 3));
            d  = 4'($urandom_range(0, 15));
            g  = 1'($urandom_range(0, 1));
            do_op(u, op, d, g);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        for (int u = 0; u < NU; u++) test_directed(u);
        test_ignore_busy(1);
        test_ignore_busy(0);
        test_back_to_back(1, 4'd3, 4'd7);
        test_back_to_back(0, 4'd8, 4'd1);
        test_back_to_back(2, 4'd15, 4'd2);
        test_abort(2);
        test_random(40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
